ifid_elastic_reg: RTL and testbench

- Parametrised successor of the fixed IF/ID pipeline register; sits between the fetch stage and the decode stage.
- Replaces the single stall-hold register with a valid/ready elastic stage backed by a one-entry skid buffer, so fetch can run at full throughput while decode back-pressure is absorbed without a combinational ready path.
- Adds a synchronous flush for branch and exception redirects; empty and flushed slots present a NOP instruction to decode.

---
 rtl/ifid_elastic_reg.sv | 150 +++++++++++++++
 tb/tb_ifid_elastic_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ifid_elastic_reg.sv
// IF/ID elastic pipeline register: valid/ready stage with a one-entry skid buffer and sync flush.
// Optional saturating decode-stall counter on stall_cnt_o when IFID_STALL_CNT_EN is defined.
module ifid_elastic_reg #(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 'h00000033,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   pc_add4_i,
  input  logic              exc_addr_i,
  input  logic [INST_W-1:0] inst_i,
`ifdef IFID_STALL_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
`endif
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   pc_add4_o,
  output logic              exc_addr_o,
  output logic [INST_W-1:0] inst_o
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e state_q, state_d;
  logic   in_ready_q;
  logic   load_main, skid_to_main, clear_main, load_skid;

  logic [XLEN-1:0]   main_pc_q, main_pc4_q, skid_pc_q, skid_pc4_q;
  logic              main_exc_q, skid_exc_q;
  logic [INST_W-1:0] main_inst_q, skid_inst_q;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    skid_to_main = 1'b0;
    clear_main   = 1'b0;
    load_skid    = 1'b0;
    if (flush_i) begin
      state_d    = StEmpty;
      clear_main = 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_valid_i) begin
            state_d   = StFull;
            load_main = 1'b1;
          end
        end
        StFull: begin
          if (in_valid_i && out_ready_i) begin
            load_main = 1'b1;
          end else if (in_valid_i) begin
            state_d   = StSkid;
            load_skid = 1'b1;
          end else if (out_ready_i) begin
            state_d    = StEmpty;
            clear_main = 1'b1;
          end
        end
        StSkid: begin
          if (out_ready_i) begin
            state_d      = StFull;
            skid_to_main = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StSkid);
    end
  end

  // Emptied slots keep pc/pc+4 but present a NOP with no exception.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_pc_q   <= '0;
      main_pc4_q  <= '0;
      main_exc_q  <= 1'b0;
      main_inst_q <= NOP_INST;
    end else if (load_main) begin
      main_pc_q   <= pc_i;
      main_pc4_q  <= pc_add4_i;
      main_exc_q  <= exc_addr_i;
      main_inst_q <= inst_i;
    end else if (skid_to_main) begin
      main_pc_q   <= skid_pc_q;
      main_pc4_q  <= skid_pc4_q;
      main_exc_q  <= skid_exc_q;
      main_inst_q <= skid_inst_q;
    end else if (clear_main) begin
      main_exc_q  <= 1'b0;
      main_inst_q <= NOP_INST;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_pc_q   <= '0;
      skid_pc4_q  <= '0;
      skid_exc_q  <= 1'b0;
      skid_inst_q <= '0;
    end else if (load_skid) begin
      skid_pc_q   <= pc_i;
      skid_pc4_q  <= pc_add4_i;
      skid_exc_q  <= exc_addr_i;
      skid_inst_q <= inst_i;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != StEmpty);
  assign pc_o        = main_pc_q;
  assign pc_add4_o   = main_pc4_q;
  assign exc_addr_o  = main_exc_q;
  assign inst_o      = main_inst_q;

`ifdef IFID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Only rst clears the counter; a flush leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid_o && !out_ready_i && !flush_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_ifid_elastic_reg.sv
// Self-checking bench for ifid_elastic_reg: directed scenarios plus random traffic checked
// against a queue-based FIFO model of the stage (capacity two, head presented to decode).
module tb_ifid_elastic_reg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam logic [31:0] NOP    = 32'h00000033;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0, exc_addr_i = 1'b0;
  logic [XLEN-1:0]   pc_i = '0, pc_add4_i = '0;
  logic [INST_W-1:0] inst_i = '0;
  logic              in_ready_o, out_valid_o, exc_addr_o;
  logic [XLEN-1:0]   pc_o, pc_add4_o;
  logic [INST_W-1:0] inst_o;
`ifdef IFID_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt_o;
`endif

  ifid_elastic_reg #(.XLEN(XLEN), .INST_W(INST_W), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .pc_i       (pc_i),
    .pc_add4_i  (pc_add4_i),
    .exc_addr_i (exc_addr_i),
    .inst_i     (inst_i),
`ifdef IFID_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .pc_o       (pc_o),
    .pc_add4_o  (pc_add4_o),
    .exc_addr_o (exc_addr_o),
    .inst_o     (inst_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        exc;
    logic [31:0] inst;
  } ent_t;

  int unsigned      cmp = 0, mis = 0;
  ent_t             q[$];
  logic [31:0]      m_pc = '0, m_pc4 = '0;
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: entries queue up to two deep; decode sees the head, or NOP with the last pc when empty.
  task automatic model_step();
    bit ov = (q.size() > 0);
    bit ir = (q.size() < 2);
    if (ov && !out_ready_i && !flush_i && (m_cnt != '1)) m_cnt = m_cnt + 1'b1;
    if (flush_i) q.delete();
    else begin
      if (ov && out_ready_i) void'(q.pop_front());
      if (in_valid_i && ir) q.push_back({pc_i, pc_add4_i, exc_addr_i, inst_i});
    end
    if (q.size() > 0) begin
      m_pc  = q[0].pc;
      m_pc4 = q[0].pc4;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc  = '0;
    m_pc4 = '0;
    m_cnt = '0;
  endtask

  task automatic check_all(string tag);
    bit ne = (q.size() > 0);
    chk({tag, ".out_valid"}, 64'(out_valid_o), 64'(ne));
    chk({tag, ".in_ready"}, 64'(in_ready_o), 64'(q.size() < 2));
    chk({tag, ".pc"}, 64'(pc_o), 64'(ne ? q[0].pc : m_pc));
    chk({tag, ".pc_add4"}, 64'(pc_add4_o), 64'(ne ? q[0].pc4 : m_pc4));
    chk({tag, ".exc"}, 64'(exc_addr_o), 64'(ne ? q[0].exc : 1'b0));
    chk({tag, ".inst"}, 64'(inst_o), 64'(ne ? q[0].inst : NOP));
`ifdef IFID_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'(m_cnt));
`endif
  endtask

  task automatic drive(bit v, bit r, bit f, logic [31:0] pc);
    in_valid_i  = v;
    out_ready_i = r;
    flush_i     = f;
    if (v) begin
      pc_i       = pc;
      pc_add4_i  = pc + 32'd4;
      exc_addr_i = pc[1];
      inst_i     = $urandom;
    end else begin
      pc_i       = 'x;
      pc_add4_i  = 'x;
      exc_addr_i = 1'bx;
      inst_i     = 'x;
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  initial begin
    drive(0, 0, 0, 0);
    #12 rst = 1'b0;
    model_reset();
    chk("rst.out_valid", 64'(out_valid_o), 64'd0);
    chk("rst.inst", 64'(inst_o), 64'(NOP));
    chk("rst.in_ready", 64'(in_ready_o), 64'd1);
    chk("rst.pc", 64'(pc_o), 64'd0);
    step("idle");

    // Streaming at full rate.
    drive(1, 1, 0, 32'h100); step("stream0");
    chk("stream0.pc_seq", 64'(pc_o), 64'h100);
    drive(1, 1, 0, 32'h104); step("stream1");
    chk("stream1.pc_seq", 64'(pc_o), 64'h104);
    drive(1, 1, 0, 32'h108); step("stream2");
    chk("stream2.pc_seq", 64'(pc_o), 64'h108);
    chk("stream2.in_ready", 64'(in_ready_o), 64'd1);
    drive(0, 1, 0, 0); step("stream_drain");

    // Back-pressure fills the skid entry.
    drive(1, 1, 0, 32'h200); step("bp0");
    drive(1, 0, 0, 32'h204); step("bp1");
    chk("bp1.in_ready", 64'(in_ready_o), 64'd0);
    chk("bp1.pc_held", 64'(pc_o), 64'h200);
    drive(1, 0, 0, 32'h2F0); step("bp_ignored");
    drive(0, 1, 0, 0); step("bp2");
    chk("bp2.pc_second", 64'(pc_o), 64'h204);
    step("bp3");
    chk("bp3.empty", 64'(out_valid_o), 64'd0);

    // Flush while the skid is occupied.
    drive(1, 1, 0, 32'h300); step("fl0");
    drive(1, 0, 0, 32'h304); step("fl1");
    drive(1, 0, 1, 32'h308); step("fl2");
    chk("fl2.out_valid", 64'(out_valid_o), 64'd0);
    chk("fl2.inst", 64'(inst_o), 64'(NOP));
    chk("fl2.exc", 64'(exc_addr_o), 64'd0);
    chk("fl2.in_ready", 64'(in_ready_o), 64'd1);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("fl_after");
      chk("fl_after.no308", 64'(pc_o == 32'h308), 64'd0);
    end

`ifdef IFID_STALL_CNT_EN
    // Saturating stall counter survives flush, cleared by reset.
    drive(1, 0, 0, 32'h600); step("sc0");
    drive(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("sc_hold");
    chk("sc.saturated", 64'(stall_cnt_o), 64'd15);
    drive(0, 0, 1, 0); step("sc_flush");
    chk("sc.after_flush", 64'(stall_cnt_o), 64'd15);
    drive(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 model_reset();
    chk("sc.after_rst", 64'(stall_cnt_o), 64'd0);
    #1 rst = 1'b0;
`endif

    // Asynchronous reset between clock edges while FULL.
    drive(1, 0, 0, 32'h400); step("ar0");
    #2 rst = 1'b1;
    #1;
    chk("ar.out_valid", 64'(out_valid_o), 64'd0);
    chk("ar.in_ready", 64'(in_ready_o), 64'd1);
    chk("ar.inst", 64'(inst_o), 64'(NOP));
    chk("ar.pc", 64'(pc_o), 64'd0);
    chk("ar.exc", 64'(exc_addr_o), 64'd0);
    model_reset();
    check_all("ar_model");
    #1 rst = 1'b0;
    drive(1, 1, 0, 32'h500); step("ar1");
    chk("ar1.pc", 64'(pc_o), 64'h500);
    chk("ar1.valid", 64'(out_valid_o), 64'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 3) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0, $urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
